// File: rtl/step_clock_ctrl.sv
// Pushbutton front-end and processor clock-enable generator: synchronises and
// debounces the keys, then issues StepEn in single-step, free-run, burst or halt mode.
module step_clock_ctrl #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DIV_WIDTH       = 26,
  parameter int CNT_WIDTH       = 16,
  parameter int STEP_KEY        = 3
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [NKEYS-1:0]     KEYn,
  input  logic [1:0]           Mode,
  input  logic [DIV_WIDTH-1:0] Div,
  input  logic [CNT_WIDTH-1:0] BurstLen,
  output logic [NKEYS-1:0]     KeyLevel,
  output logic [NKEYS-1:0]     KeyPress,
  output logic                 StepEn,
  output logic                 Busy,
  output logic [CNT_WIDTH-1:0] StepCount
);

  // state   | meaning
  // S_IDLE  | no timed stepping; single-step presses or burst starts accepted here
  // S_FREE  | free-run, StepEn on every divider tick
  // S_BURST | counted burst in progress, Busy high

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] MODE_STEP  = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_FREE, S_BURST} state_t;

  logic [NKEYS-1:0]     sync1_q, sync2_q;
  logic [NKEYS-1:0]     level_q, level_d;
  logic [NKEYS-1:0]     press_q, press_d;
  logic [DBW-1:0]       dbc_q [NKEYS];
  logic [DBW-1:0]       dbc_d [NKEYS];

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, div_inc;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 step_q, step_d;
  logic                 busy_q, busy_d;
  logic                 tick;
  logic                 step_press;

  // Synchronisers hold the inverted key, so '0' is the released level.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < NKEYS; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q <= ~KEYn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      for (int i = 0; i < NKEYS; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  always_comb begin
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < NKEYS; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (dbc_q[i] == DBW'(DEBOUNCE_CYCLES)) begin
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  // Divider is zero in IDLE, so the transition cycle counts as the first period cycle.
  assign tick       = (div_q >= Div);
  assign div_inc    = tick ? '0 : div_q + 1'b1;
  assign step_press = press_q[STEP_KEY];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      rem_q   <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_q + CNT_WIDTH'(step_q);
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    rem_d   = rem_q;
    step_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        case (Mode)
          MODE_STEP: step_d = step_press;
          MODE_FREE: begin
            state_d = S_FREE;
            step_d  = tick;
            div_d   = div_inc;
          end
          MODE_BURST: begin
            if (step_press && (BurstLen != '0)) begin
              state_d = S_BURST;
              step_d  = tick;
              div_d   = div_inc;
              rem_d   = BurstLen - CNT_WIDTH'(tick);
            end
          end
          default: ;
        endcase
      end
      S_FREE: begin
        if (Mode != MODE_FREE) begin
          state_d = S_IDLE;
        end else begin
          step_d = tick;
          div_d  = div_inc;
        end
      end
      S_BURST: begin
        // rem_q==0 here means the final StepEn is on the output this cycle.
        if ((Mode != MODE_BURST) || (rem_q == '0)) begin
          state_d = S_IDLE;
          rem_d   = '0;
        end else begin
          step_d = tick;
          div_d  = div_inc;
          if (tick) rem_d = rem_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_BURST);
  end

  assign KeyLevel  = level_q;
  assign KeyPress  = press_q;
  assign StepEn    = step_q;
  assign Busy      = busy_q;
  assign StepCount = cnt_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Directed bench for step_clock_ctrl: expected StepEn cycles are queued as stimulus
// is applied and matched by a monitor; other outputs are checked inline.
module tb_step_clock_ctrl;

  localparam int NKEYS = 4;
  localparam int DB    = 4;
  localparam int DW    = 26;
  localparam int CW    = 16;

  logic            Clock = 1'b0;
  logic            Resetn;
  logic [NKEYS-1:0] KEYn;
  logic [1:0]      Mode;
  logic [DW-1:0]   Div;
  logic [CW-1:0]   BurstLen;
  logic [NKEYS-1:0] KeyLevel;
  logic [NKEYS-1:0] KeyPress;
  logic            StepEn;
  logic            Busy;
  logic [CW-1:0]   StepCount;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  logic [CW-1:0] sc_exp;

  step_clock_ctrl #(
    .NKEYS(NKEYS), .DEBOUNCE_CYCLES(DB), .DIV_WIDTH(DW), .CNT_WIDTH(CW), .STEP_KEY(3)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .KEYn(KEYn), .Mode(Mode), .Div(Div),
    .BurstLen(BurstLen), .KeyLevel(KeyLevel), .KeyPress(KeyPress), .StepEn(StepEn),
    .Busy(Busy), .StepCount(StepCount)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_step(input int c);
    exp_q.push_back(c);
    sc_exp++;
  endtask

  // Every StepEn cycle must match the oldest queued expectation.
  always @(posedge Clock) begin
    int want;
    #1;
    if (StepEn === 1'b1) begin
      want = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      chkw("stepen_cycle", cyc, want);
    end
  end

  task automatic key_step();
    int p;
    p = cyc;
    KEYn[3] = 1'b0;
    push_step(p + 8);
    for (int t = 1; t <= 20; t++) begin
      step();
      chk1("step_keypress", KeyPress[3], t == 7);
      chk1("step_keylevel", KeyLevel[3], (t >= 7) && (t <= 12));
      if (t == 6) KEYn[3] = 1'b1;
    end
  endtask

  task automatic burst(input int dv, input int len, input bit repress, input int abort_t);
    int p, last, stop, ntot;
    Mode     = 2'b10;
    Div      = DW'(dv);
    BurstLen = CW'(len);
    step();
    p    = cyc;
    last = 7 + len * (dv + 1);
    stop = (abort_t > 0) ? abort_t : last;
    ntot = (last + 6 > 22) ? last + 6 : 22;
    for (int k = 1; k <= len; k++)
      if (7 + k * (dv + 1) <= stop) push_step(p + 7 + k * (dv + 1));
    KEYn[3] = 1'b0;
    for (int t = 1; t <= ntot; t++) begin
      step();
      chk1("burst_busy", Busy, (len != 0) && (t >= 8) && (t <= stop));
      chk1("burst_keypress", KeyPress[3], (t == 7) || (repress && (t == 20)));
      if ((t == 6) || (t == 19)) KEYn[3] = 1'b1;
      if (repress && (t == 13)) KEYn[3] = 1'b0;
      if (t == abort_t) Mode = 2'b00;
    end
    chkw("burst_pending", exp_q.size(), 0);
    chkw("burst_stepcount", 32'(StepCount), 32'(sc_exp));
  endtask

  initial begin
    int n0, f, p, r;
    Resetn   = 1'b0;
    KEYn     = '1;
    Mode     = 2'b11;
    Div      = '0;
    BurstLen = '0;
    sc_exp   = '0;
    #1;
    chkw("rst_keylevel", 32'(KeyLevel), 0);
    chkw("rst_keypress", 32'(KeyPress), 0);
    chk1("rst_stepen", StepEn, 1'b0);
    chk1("rst_busy", Busy, 1'b0);
    chkw("rst_stepcount", 32'(StepCount), 0);
    repeat (3) step();
    Resetn = 1'b1;
    repeat (2) step();

    // StepCount wrap: 65535 continuous pulses, then one more
    Mode = 2'b01;
    Div  = '0;
    n0   = cyc;
    for (int i = 1; i <= 65535; i++) push_step(n0 + i);
    repeat (65535) step();
    Mode = 2'b11;
    step();
    chkw("wrap_ffff", 32'(StepCount), 32'h0000_FFFF);
    n0   = cyc;
    Mode = 2'b01;
    push_step(n0 + 1);
    step();
    Mode = 2'b11;
    step();
    chkw("wrap_zero", 32'(StepCount), 32'(sc_exp));
    chkw("wrap_pending", exp_q.size(), 0);

    // Debounce with a bounce: low 3, high 1, low 10
    step();
    KEYn[3] = 1'b0;
    repeat (3) step();
    KEYn[3] = 1'b1;
    step();
    KEYn[3] = 1'b0;
    f = cyc;
    for (int t = 1; t <= 20; t++) begin
      step();
      chk1("db_keypress", KeyPress[3], t == 7);
      chk1("db_keylevel", KeyLevel[3], (t >= 7) && (t <= 16));
      if (t == 10) KEYn[3] = 1'b1;
    end
    chkw("db_cycles", cyc - f, 20);

    // Single step, three presses
    Mode = 2'b00;
    repeat (3) key_step();
    step();
    chkw("step_pending", exp_q.size(), 0);
    chkw("step_stepcount", 32'(StepCount), 3);

    // Free-run Div=3 for 40 cycles, then halt
    Mode = 2'b01;
    Div  = DW'(3);
    n0   = cyc;
    for (int k = 1; k <= 10; k++) push_step(n0 + 4 * k);
    repeat (40) step();
    Mode = 2'b11;
    step();
    chkw("free_div_cleared", 32'(dut.div_q), 0);
    chk1("free_busy", Busy, 1'b0);
    repeat (5) step();
    chkw("free_pending", exp_q.size(), 0);
    chkw("free_stepcount", 32'(StepCount), 13);

    // Bursts: plain, with re-press while busy, zero length, aborted
    burst(1, 5, 1'b0, 0);
    chkw("burst_total", 32'(StepCount), 18);
    burst(3, 5, 1'b1, 0);
    burst(1, 0, 1'b0, 0);
    burst(1, 5, 1'b0, 11);
    chkw("abort_total", 32'(StepCount), 25);

    // Reset during a burst with the key held throughout
    Mode     = 2'b10;
    Div      = DW'(1);
    BurstLen = CW'(5);
    step();
    p = cyc;
    KEYn[3] = 1'b0;
    push_step(p + 9);
    for (int t = 1; t <= 10; t++) begin
      step();
      chk1("rmb_busy", Busy, t >= 8);
    end
    Resetn = 1'b0;
    Mode   = 2'b11;
    sc_exp = '0;
    #1;
    chkw("rmb_keylevel", 32'(KeyLevel), 0);
    chkw("rmb_keypress", 32'(KeyPress), 0);
    chk1("rmb_stepen", StepEn, 1'b0);
    chk1("rmb_busy_async", Busy, 1'b0);
    chkw("rmb_stepcount", 32'(StepCount), 0);
    step();
    step();
    Resetn = 1'b1;
    r = cyc;
    for (int t = 1; t <= 10; t++) begin
      step();
      chk1("rmb_keypress_after", KeyPress[3], t == 7);
      chk1("rmb_keylevel_after", KeyLevel[3], t >= 7);
      chk1("rmb_idle_busy", Busy, 1'b0);
    end
    chkw("rmb_cycles", cyc - r, 10);
    KEYn[3] = 1'b1;
    repeat (10) step();
    chkw("rmb_pending", exp_q.size(), 0);
    chkw("rmb_stepcount_after", 32'(StepCount), 32'(sc_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_clock_ctrl.md
# step_clock_ctrl

Board-facing clocking and pushbutton front-end for the processor top level. It replaces driving the processor clock directly from a raw pushbutton. The block synchronises and debounces NKEYS active-low pushbuttons and produces a single-cycle clock enable, StepEn, for the processor datapath. StepEn can be generated in one of four modes: single-step, free-run with a divider, counted burst, or halt. All logic runs on the board's system clock; nothing downstream is clocked by a key.

## Interface
- NKEYS, 4, number of pushbuttons handled.
- DEBOUNCE_CYCLES, 500000, required stable cycles before a key level is accepted (≥2).
- DIV_WIDTH, 26, width of the divider and Div.
- CNT_WIDTH, 16, width of BurstLen and StepCount.
- STEP_KEY, 3, index of the key that triggers steps and bursts.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- KEYn  in  NKEYS  raw pushbuttons, asynchronous, low = pressed.
- Mode  in  2  00 step, 01 free-run, 10 burst, 11 halt. Synchronous to Clock.
- Div  in  DIV_WIDTH  divider period minus 1.
- BurstLen  in  CNT_WIDTH  StepEn pulses per burst. Sampled at burst start.
- KeyLevel  out  NKEYS  debounced key state, 1 = pressed.
- KeyPress  out  NKEYS  one-cycle pulse on each debounced press.
- StepEn  out  1  one-cycle processor clock enable. Registered.
- Busy  out  1  burst in progress.
- StepCount  out  CNT_WIDTH  total StepEn pulses since reset. Wraps modulo 2^CNT_WIDTH.

## Operation
- **Reset.** Resetn low clears everything asynchronously:
  - KeyLevel, KeyPress, StepEn, Busy and StepCount = 0.
  - Synchronisers preset to "released".
  - Debounce counters, divider and remaining-count = 0.
  - FSM = IDLE.
- **Key path (per key).**
  - Two-flop synchroniser on ~KEYn.
  - Debounce counter clears whenever the synced value equals KeyLevel; otherwise it increments.
  - When the mismatch has persisted DEBOUNCE_CYCLES cycles, KeyLevel takes the synced value and the counter clears.
  - Any bounce restarts the count.
  - KeyPress[i] = 1 for exactly the cycle in which KeyLevel[i] goes 0→1. Releases produce no pulse.
- **Divider.**
  - Counts up each cycle while the FSM is FREE or BURST.
  - When divider ≥ Div, it emits a tick and clears. Using ≥ means a Div reduced mid-period takes effect at once with no wrap-through.
  - Cleared in IDLE.
- **FSM states:** IDLE, FREE, BURST.
  - IDLE, Mode=00: KeyPress[STEP_KEY] → StepEn high the next cycle.
  - IDLE, Mode=01: go to FREE.
  - IDLE, Mode=10: KeyPress[STEP_KEY] with BurstLen≠0 → go to BURST, remaining = BurstLen, Busy=1. BurstLen=0 is ignored.
  - IDLE, Mode=11: nothing.
  - FREE: StepEn = tick. Mode≠01 → IDLE next cycle.
  - BURST: StepEn = tick, and each tick decrements remaining. The tick that brings remaining to 0 returns the FSM to IDLE. Mode≠10 aborts to IDLE the next cycle with no further StepEn. Key presses during BURST are ignored.
- StepCount increments on every cycle with StepEn=1.
- Processor-facing semantics: exactly one StepEn pulse per single-step press. StepEn is never high for two consecutive cycles unless Div=0 in FREE or BURST.

## Timing
- **Key latency.** KeyLevel/KeyPress rise DEBOUNCE_CYCLES+2 rising edges after the first edge that samples KEYn low, provided KEYn stays low throughout. Release follows the same latency.
- **Step mode.** StepEn is high in the cycle after KeyPress[STEP_KEY]. End-to-end, that is DEBOUNCE_CYCLES+3 edges after the press.
- **Free-run.** The first StepEn occurs Div+1 cycles after entering FREE, then every Div+1 cycles. With Div=0, StepEn is continuously high.
- **Burst.**
  - Busy rises the cycle after KeyPress.
  - StepEn is high on every (Div+1)th Busy cycle.
  - Busy lasts exactly BurstLen·(Div+1) cycles.
  - The last StepEn and the last Busy cycle coincide; both are 0 the next cycle.
- **Mode change.** Mode is sampled every cycle. On a change, the divider clears and any partial period is discarded.
- **Reset mid-operation.** Resetn asserted in any state clears all outputs immediately. After release, the block starts in IDLE with keys treated as released. A key still held through reset is accepted only after the full debounce interval.

## Test plan
Benches use DEBOUNCE_CYCLES=4.
- **Debounce.** KEYn[3] low for 3 cycles, high 1, low 10 → one KeyPress[3] pulse, 6 edges after the final fall. KeyLevel[3] stays 1 until release plus 6 edges.
- **Single step.** Mode=00, three clean presses of KEYn[3] → three StepEn pulses, each one cycle wide and one cycle after KeyPress[3]. StepCount=3.
- **Free-run.** Mode=01, Div=3, 40 cycles → StepEn every 4th cycle, 10 pulses. Switch to Mode=11 → StepEn stays 0 and the divider is 0.
- **Burst.** Mode=10, Div=1, BurstLen=5, press key → Busy high for 10 cycles. StepEn high on Busy cycles 2, 4, 6, 8 and 10. StepCount +5. A second press during Busy is ignored.
- **Boundaries.**
  - BurstLen=0 plus a press → Busy never rises.
  - StepCount preloaded near wrap by 2^CNT_WIDTH−1 pulses (Div=0 free-run) → wraps to 0.
  - Mode changed to 00 mid-burst → Busy 0 the next cycle and no further StepEn.
- **Reset mid-burst.** Resetn low during BURST → all outputs 0 asynchronously. After release, FSM is in IDLE, and a held key produces KeyPress only after 6 edges.
